// File: rtl/n64_vdemux_vinfo_if.sv
// N64 video demux bus: multiplexed VD input side plus demuxed pixel and
// stream-info outputs. The demuxer connects through the slave modport.
interface n64_vdemux_vinfo_if #(
    parameter int unsigned color_width_i = 7
) ();
    logic                     nVDSYNC;
    logic [color_width_i-1:0] VD_i;

    logic                     vdata_valid;
    logic                     nVSYNC;
    logic                     nCLAMP;
    logic                     nHSYNC;
    logic                     nCSYNC;
    logic [color_width_i-1:0] R_o;
    logic [color_width_i-1:0] G_o;
    logic [color_width_i-1:0] B_o;

    logic                     locked;
    logic                     sync_err;
    logic [9:0]               lines_per_field;
    logic                     pal;
    logic                     interlaced;
    logic                     field;

    modport master (
        output nVDSYNC, VD_i,
        input  vdata_valid, nVSYNC, nCLAMP, nHSYNC, nCSYNC, R_o, G_o, B_o,
        input  locked, sync_err, lines_per_field, pal, interlaced, field
    );

    modport slave (
        input  nVDSYNC, VD_i,
        output vdata_valid, nVSYNC, nCLAMP, nHSYNC, nCSYNC, R_o, G_o, B_o,
        output locked, sync_err, lines_per_field, pal, interlaced, field
    );
endinterface

// File: rtl/n64_vdemux_vinfo.sv
// N64 video demultiplexer: tracks the 4-word sync/R/G/B sequence on VD,
// emits one strobed pixel per sequence, and derives lines per field,
// PAL/NTSC, interlace and field parity from the demuxed sync bits.
module n64_vdemux_vinfo #(
    parameter int unsigned color_width_i    = 7,
    parameter logic [9:0]  lines_pal_thresh = 10'd290
) (
    input logic               VCLK,
    input logic               VRST,
    n64_vdemux_vinfo_if.slave bus
);

    localparam logic StUnlocked = 1'b0;
    localparam logic StLocked   = 1'b1;

    // Input stage
    logic                     nvdsync_s1_q;
    logic [color_width_i-1:0] vd_s1_q;

    // Phase tracker
    logic                     state_q, state_d;
    logic [1:0]               phase_q, phase_d;
    logic [3:0]               sync_hold_q, sync_hold_d;
    logic [color_width_i-1:0] r_hold_q, r_hold_d;
    logic [color_width_i-1:0] g_hold_q, g_hold_d;
    logic                     pix_done;
    logic                     err_d;

    // Pixel outputs; sync nibble is {nVSYNC, nCLAMP, nHSYNC, nCSYNC}
    logic                     valid_q;
    logic                     err_q;
    logic [3:0]               sync_q;
    logic [color_width_i-1:0] r_q, g_q, b_q;

    // Stream info
    logic                     hs_prev_q, vs_prev_q;
    logic [9:0]               line_cnt_q;
    logic [9:0]               lpf_q;
    logic                     pal_q, interlaced_q, field_q;
    logic                     hs_edge, vs_edge, diff_one;
    logic [9:0]               cnt_inc;

    // Register the raw VD bus once; every decision uses these values.
    always_ff @(posedge VCLK) begin
        if (VRST) begin
            nvdsync_s1_q <= 1'b1;
            vd_s1_q      <= '0;
        end else begin
            nvdsync_s1_q <= bus.nVDSYNC;
            vd_s1_q      <= bus.VD_i;
        end
    end

    // Word-sequence tracker: sync word always restarts a pixel.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        sync_hold_d = sync_hold_q;
        r_hold_d    = r_hold_q;
        g_hold_d    = g_hold_q;
        pix_done    = 1'b0;
        err_d       = 1'b0;
        if (!nvdsync_s1_q) begin
            // A sync arriving mid-pixel drops the partial pixel.
            err_d       = (state_q == StLocked) && (phase_q != 2'd0);
            sync_hold_d = vd_s1_q[3:0];
            phase_d     = 2'd1;
            state_d     = StLocked;
        end else if (state_q == StLocked) begin
            unique case (phase_q)
                2'd0: begin
                    err_d   = 1'b1;
                    state_d = StUnlocked;
                end
                2'd1: begin
                    r_hold_d = vd_s1_q;
                    phase_d  = 2'd2;
                end
                2'd2: begin
                    g_hold_d = vd_s1_q;
                    phase_d  = 2'd3;
                end
                2'd3: begin
                    pix_done = 1'b1;
                    phase_d  = 2'd0;
                end
            endcase
        end
    end

    // Tracker state and holding registers.
    always_ff @(posedge VCLK) begin
        if (VRST) begin
            state_q     <= StUnlocked;
            phase_q     <= 2'd0;
            sync_hold_q <= 4'hF;
            r_hold_q    <= '0;
            g_hold_q    <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            sync_hold_q <= sync_hold_d;
            r_hold_q    <= r_hold_d;
            g_hold_q    <= g_hold_d;
        end
    end

    // Publish a complete pixel in one step; hold between strobes.
    always_ff @(posedge VCLK) begin
        if (VRST) begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            sync_q  <= 4'hF;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
        end else begin
            valid_q <= pix_done;
            err_q   <= err_d;
            if (pix_done) begin
                sync_q <= sync_hold_q;
                r_q    <= r_hold_q;
                g_q    <= g_hold_q;
                b_q    <= vd_s1_q;
            end
        end
    end

    // Edges are judged against the previous valid pixel only.
    assign hs_edge  = pix_done && hs_prev_q && !sync_hold_q[1];
    assign vs_edge  = pix_done && vs_prev_q && !sync_hold_q[3];
    assign cnt_inc  = (line_cnt_q == 10'd1023) ? line_cnt_q : line_cnt_q + 10'd1;
    assign diff_one = ({1'b0, line_cnt_q} == {1'b0, lpf_q} + 11'd1) ||
                      ({1'b0, lpf_q} == {1'b0, line_cnt_q} + 11'd1);

    // Line counting and per-field classification on vsync edges.
    always_ff @(posedge VCLK) begin
        if (VRST) begin
            hs_prev_q    <= 1'b1;
            vs_prev_q    <= 1'b1;
            line_cnt_q   <= '0;
            lpf_q        <= '0;
            pal_q        <= 1'b0;
            interlaced_q <= 1'b0;
            field_q      <= 1'b0;
        end else begin
            if (pix_done) begin
                hs_prev_q <= sync_hold_q[1];
                vs_prev_q <= sync_hold_q[3];
            end
            if (vs_edge) begin
                lpf_q        <= line_cnt_q;
                pal_q        <= (line_cnt_q >= lines_pal_thresh);
                interlaced_q <= diff_one;
                field_q      <= diff_one && (line_cnt_q < lpf_q);
                // The hsync on the vsync pixel is the first line of the new field.
                line_cnt_q   <= hs_edge ? 10'd1 : 10'd0;
            end else if (hs_edge) begin
                line_cnt_q <= cnt_inc;
            end
        end
    end

    assign bus.vdata_valid     = valid_q;
    assign bus.sync_err        = err_q;
    assign bus.nVSYNC          = sync_q[3];
    assign bus.nCLAMP          = sync_q[2];
    assign bus.nHSYNC          = sync_q[1];
    assign bus.nCSYNC          = sync_q[0];
    assign bus.R_o             = r_q;
    assign bus.G_o             = g_q;
    assign bus.B_o             = b_q;
    assign bus.locked          = (state_q == StLocked);
    assign bus.lines_per_field = lpf_q;
    assign bus.pal             = pal_q;
    assign bus.interlaced      = interlaced_q;
    assign bus.field           = field_q;

endmodule

// File: doc/n64_vdemux_vinfo.md
N64_VDEMUX_VINFO -- requirements
Module: n64_vdemux_vinfo

Interface
REQ-001 Parameter color_width_i, default 7: width of the N64 VD_i bus and of each demuxed colour word.
REQ-002 Parameter lines_pal_thresh, default 10'd290: minimum lines per field at which the stream is classified PAL.
REQ-003 VCLK  in  1: the only clock; all logic on the rising edge.
REQ-004 VRST  in  1: reset, synchronous and active-high, sampled on the VCLK rising edge.
REQ-005 nVDSYNC  in  1: N64 video sync-word marker, active low.
REQ-006 VD_i  in  color_width_i: N64 multiplexed video data.
REQ-007 vdata_valid  out  1: one-cycle strobe; the sync and colour outputs hold a new pixel.
REQ-008 nVSYNC, nCLAMP, nHSYNC, nCSYNC  out  1 each: demuxed sync bits, taken from VD_i[3], VD_i[2], VD_i[1] and VD_i[0] of the sync word.
REQ-009 R_o, G_o, B_o  out  color_width_i each: demuxed colour words.
REQ-010 locked  out  1: phase tracker is locked to the 4-word sequence.
REQ-011 sync_err  out  1: one-cycle pulse on a broken word sequence.
REQ-012 lines_per_field  out  10: hsync count of the last complete field.
REQ-013 pal  out  1: stream is classified PAL.
REQ-014 interlaced  out  1: stream is classified interlaced.
REQ-015 field  out  1: field parity of the current field.

Function
REQ-016 nVDSYNC and VD_i SHALL be registered once on entry (stage S1), and all decisions SHALL use the S1 values.
REQ-017 The tracker SHALL have two states, UNLOCKED and LOCKED, plus a 2-bit phase counter.
REQ-018 UNLOCKED, S1 nVDSYNC=0: capture the sync bits into a holding register, set phase=1, go to LOCKED.
REQ-019 UNLOCKED, any other S1 word: discard it; no output.
REQ-020 LOCKED, phases 1, 2, 3: capture S1 VD_i as R, G and B respectively; phase increments and wraps 3->0.
REQ-021 LOCKED, phase 0: S1 nVDSYNC SHALL be 0; capture the sync bits and set phase=1.
REQ-022 Early sync (S1 nVDSYNC=0 while phase is 1, 2 or 3): pulse sync_err, discard the partial pixel, capture the new sync bits, set phase=1, stay LOCKED.
REQ-023 Missing sync (S1 nVDSYNC=1 at phase 0): pulse sync_err and go to UNLOCKED; the word is discarded.
REQ-024 On the cycle the B word is captured, all seven sync/colour outputs SHALL update together on the next VCLK edge, with vdata_valid=1 for exactly that one cycle.
REQ-025 Latency: 2 VCLK edges from the B word on the pins to vdata_valid=1.
REQ-026 Outputs SHALL hold their values between strobes.
REQ-027 locked SHALL equal (state==LOCKED), registered.
REQ-028 Line counter (10 bit): increments on each valid pixel whose nHSYNC is 0 while the previous valid pixel had nHSYNC=1; it saturates at 1023.
REQ-029 nVSYNC falling edge, detected on valid pixels only: latch the counter into lines_per_field and reset the counter to 0; the same pixel's hsync edge, if any, counts into the new field (counter becomes 1).
REQ-030 On the same vsync edge, pal SHALL be set to (latched count >= lines_pal_thresh).
REQ-031 On the same vsync edge, interlaced SHALL be set to 1 iff the new and the previous latched counts differ by exactly 1, else 0.
REQ-032 On the same vsync edge, field SHALL be set to 1 iff the new count is less than the previous count; field SHALL be 0 when interlaced=0.
REQ-033 The vinfo outputs (lines_per_field, pal, interlaced, field) SHALL change only on vsync edges.
REQ-034 A missing-sync event SHALL NOT clear the line counter.
REQ-035 Sync-edge history SHALL be updated only on valid pixels.

Reset
REQ-036 When VRST=1, after the next VCLK edge: state UNLOCKED and phase 0.
REQ-037 After that edge, vdata_valid, sync_err and locked SHALL be 0.
REQ-038 After that edge, all sync outputs and their edge history SHALL be 1, and R_o/G_o/B_o SHALL be 0.
REQ-039 After that edge, the line counter and lines_per_field SHALL be 0, pal, interlaced and field SHALL be 0, and the previous-count register SHALL be 0.
REQ-040 Reset asserted mid-pixel SHALL discard the partial pixel, and no strobe SHALL follow it.

Verification
REQ-041 Clean stream: sync 0x7F, R=0x11, G=0x22, B=0x33, repeated -> after the first B, valid every 4th cycle, 2 edges after B; R_o=0x11, G_o=0x22, B_o=0x33; locked=1; sync_err never pulses.
REQ-042 Early sync: nVDSYNC=0 at phase 2 -> sync_err pulses once, no valid for the partial pixel, next complete pixel output correctly.
REQ-043 Missing sync: nVDSYNC held 1 for 6 words after lock -> sync_err pulses once, locked=0, no valid until the next sync word plus 3 colour words.
REQ-044 NTSC 240p: fields of 263 hsyncs -> lines_per_field=263, pal=0, interlaced=0, field=0.
REQ-045 NTSC 480i: fields alternating 263/262 -> from the second field on, interlaced=1; field toggles, with field=1 after each 262 field.
REQ-046 PAL: 313/312 fields -> pal=1, interlaced=1.
REQ-047 VRST asserted between the G and B words -> no strobe follows, all outputs return to their reset values, and relock occurs on the next sync word.
